fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Fetch-stage program counter register and IF/ID pipeline register for the pipelined RV32I core. It consumes `PCN` from the PC-source mux and produces `PCF`/`PCPlus4F`, which feed back into that mux. It drives a request/acknowledge handshake to instruction memory and delivers fetched instructions to decode. Stall, flush and execute-stage redirect handling live here, including discarding an in-flight fetch after a taken branch.

## Interface
- `DATA_WIDTH`, 32, PC/instruction width.
- `RESET_PC`, 32'h0000_0000, PCF value after reset; must be word-aligned.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `PCN` in DATA_WIDTH: next PC from PC-source mux.
- `PCSrcE1bit` in 1: execute-stage redirect (taken branch/jump); `PCN` then holds the target.
- `StallF` in 1: hold PCF and IF/ID.
- `FlushD` in 1: invalidate IF/ID.
- `imem_req` out 1: fetch request.
- `imem_addr` out DATA_WIDTH: fetch address, always equals `PCF`.
- `imem_ack` in 1: data valid this cycle; may be combinational from `imem_req`.
- `imem_rdata` in DATA_WIDTH: instruction word.
- `PCF` out DATA_WIDTH: current fetch PC.
- `PCPlus4F` out DATA_WIDTH: `PCF+4`, combinational.
- `InstrD` out DATA_WIDTH: decode instruction.
- `PCD`, `PCPlus4D` out DATA_WIDTH: decode PC and PC+4.
- `ValidD` out 1: IF/ID holds a real instruction.
- `misaligned_o` out 1: present only with `PC_MISALIGN_CHECK_EN`.

## Operation
- Reset values:
  - `PCF=RESET_PC`, `InstrD=32'h0000_0013` (NOP), `PCD=0`, `PCPlus4D=0`, `ValidD=0`, `misaligned_o=0`.
  - Holding buffer empty; state IDLE.
- FSM states:
  - IDLE: `imem_req=0`; always goes to REQ next cycle. Occupied only in the cycle after reset.
  - REQ: `imem_req=1`. On `imem_ack`, if decode can accept (`!StallF`), write IF/ID and load `PCF<=PCN`. On `imem_ack` with `StallF`, store rdata/PCF in the holding buffer and go to HELD.
  - HELD: `imem_req=0`. When `StallF` drops, move the buffer into IF/ID, load `PCF<=PCN`, and go to REQ.
  - DROP: `imem_req=0`. Wait for the `imem_ack` of the killed request, discard it, and go to REQ.
- IF/ID write: `InstrD<=rdata`, `PCD<=PCF`, `PCPlus4D<=PCF+4`, `ValidD<=1`.
- Redirect (`PCSrcE1bit=1`) has priority over `StallF` and any pending ack:
  - `PCF<=PCN`.
  - Buffer cleared.
  - IF/ID gets NOP with `ValidD=0`.
  - Next state: REQ if no request is outstanding or `imem_ack` arrives this cycle (its data is discarded). DROP if a request is outstanding without ack.
- `FlushD` without redirect: IF/ID gets NOP with `ValidD=0`. PCF and state are unaffected. An ack arriving the same cycle is discarded and `PCF` still advances.
- If no instruction is written and there is no stall, `ValidD<=0` (bubble). With `StallF`, IF/ID holds.
- Arithmetic: `PCF+4` wraps modulo 2^DATA_WIDTH; no carry out.

## Timing
- Ack to `ValidD=1`: 1 cycle.
- Zero-wait memory (ack combinational): one instruction per cycle.
- First request in cycle 2 after `rst` deasserts: cycle 1 is IDLE.
- `imem_addr` stable while `imem_req=1` until ack or redirect.
- Redirect to first request at the target:
  - Next cycle if nothing is in flight.
  - Otherwise one cycle after the killed ack.
- `rst` mid-transaction forces IDLE. An ack for a pre-reset request is ignored while in IDLE.

## Configuration
- `PC_MISALIGN_CHECK_EN` defined:
  - Whenever `PCF` loads `PCN` with `PCN[1:0]!=0`, load `{PCN[DATA_WIDTH-1:2],2'b00}` instead.
  - Pulse `misaligned_o` for one cycle.
- `PC_MISALIGN_CHECK_EN` not defined: `PCN` loads unmodified and the `misaligned_o` port is absent.

## Test plan
- Reset, then zero-wait memory returning `rdata=PC^32'hA5A5_0000` -> `PCF` sequence 0,4,8,… one per cycle from cycle 2. `ValidD=1` from cycle 3 with matching `PCD`/`InstrD`.
- 2-cycle-latency memory, then `PCSrcE1bit=1` with `PCN=0x100` one cycle after the request at 0x8 -> the ack for 0x8 is dropped, the next `imem_addr` is 0x100, and no `InstrD` from 0x8 ever has `ValidD=1`.
- `StallF=1` for 3 cycles across an ack at PC 0x10 -> IF/ID unchanged during the stall. The instruction from 0x10 appears the cycle after `StallF` falls, then `PCF=0x14`.
- `FlushD=1` while `ValidD=1` -> next cycle `InstrD=0x00000013`, `ValidD=0`, and PCF advances normally.
- `PCF=0xFFFF_FFFC` -> `PCPlus4F=0`, `PCPlus4D=0` after fetch.
- With `PC_MISALIGN_CHECK_EN`, redirect to `PCN=0x102` -> `PCF=0x100`, `misaligned_o=1` for exactly one cycle. Without the macro -> `PCF=0x102`.

Source files
------------

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : Fetch-stage program counter and IF/ID pipeline register for the
//            pipelined RV32I core. Drives a request/acknowledge handshake to
//            instruction memory, parks a fetched word while decode is stalled,
//            and discards an in-flight fetch killed by an execute-stage
//            redirect.
//
// Parameters
//   DATA_WIDTH  : PC / instruction width.
//   RESET_PC    : PCF value after reset (word-aligned).
//
// Ports
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   PCN           : next PC from the PC-source mux
//   PCSrcE1bit    : execute-stage redirect; PCN holds the target
//   StallF        : hold PCF and IF/ID
//   FlushD        : invalidate IF/ID
//   imem_req      : fetch request (registered)
//   imem_addr     : fetch address, always equal to PCF
//   imem_ack      : instruction data valid this cycle (may be combinational)
//   imem_rdata    : instruction word
//   PCF, PCPlus4F : current fetch PC and PCF+4 (combinational, wraps)
//   InstrD, PCD, PCPlus4D, ValidD : IF/ID register contents
//   misaligned_o  : one-cycle pulse when a misaligned PCN was force-aligned
//                   (port exists only when PC_MISALIGN_CHECK_EN is defined)
//
// Build option
//   PC_MISALIGN_CHECK_EN : when defined, every PCF load clears PCN[1:0] and
//                          pulses misaligned_o if those bits were non-zero.
//
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] PCN,
    input  logic                  PCSrcE1bit,
    input  logic                  StallF,
    input  logic                  FlushD,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD
`ifdef PC_MISALIGN_CHECK_EN
    ,
    output logic                  misaligned_o
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [DATA_WIDTH-1:0] c_NOP     = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] c_PC_STEP = DATA_WIDTH'(4);

    // Fetch handshake states
    localparam logic [1:0] c_ST_IDLE = 2'd0;  // one cycle after reset, no request
    localparam logic [1:0] c_ST_REQ  = 2'd1;  // request asserted at PCF
    localparam logic [1:0] c_ST_HELD = 2'd2;  // word parked while decode stalls
    localparam logic [1:0] c_ST_DROP = 2'd3;  // waiting for the ack of a killed fetch

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic                  r_req;
    logic [DATA_WIDTH-1:0] r_pcf;

    logic [DATA_WIDTH-1:0] r_instr_d;
    logic [DATA_WIDTH-1:0] r_pc_d;
    logic [DATA_WIDTH-1:0] r_pcp4_d;
    logic                  r_valid_d;

    logic                  r_buf_valid;
    logic [DATA_WIDTH-1:0] r_buf_instr;
    logic [DATA_WIDTH-1:0] r_buf_pc;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic                  w_in_req;
    logic                  w_in_held;
    logic                  w_fetch_accept;
    logic                  w_fetch_hold;
    logic                  w_release;
    logic                  w_pc_load;
    logic [DATA_WIDTH-1:0] w_pcn_eff;
    logic [1:0]            w_state_nxt;

    assign w_in_req  = (r_state == c_ST_REQ);
    assign w_in_held = (r_state == c_ST_HELD);

    // A redirect overrides everything: any ack arriving with it is stale.
    assign w_fetch_accept = w_in_req  &  imem_ack & ~StallF & ~PCSrcE1bit;
    assign w_fetch_hold   = w_in_req  &  imem_ack &  StallF & ~PCSrcE1bit;
    assign w_release      = w_in_held &  r_buf_valid & ~StallF & ~PCSrcE1bit;

    // PCF advances whenever a fetched word leaves the fetch stage, or on a
    // redirect. An accept that coincides with FlushD still advances PCF.
    assign w_pc_load = PCSrcE1bit | w_fetch_accept | w_release;

`ifdef PC_MISALIGN_CHECK_EN
    assign w_pcn_eff = {PCN[DATA_WIDTH-1:2], 2'b00};
`else
    assign w_pcn_eff = PCN;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                // Any ack seen here belongs to a pre-reset request: ignored.
                w_state_nxt = c_ST_REQ;
            end
            c_ST_REQ: begin
                if (PCSrcE1bit) begin
                    // Without an ack the memory still owes us a response that
                    // must be swallowed before fetching at the target.
                    w_state_nxt = imem_ack ? c_ST_REQ : c_ST_DROP;
                end else if (imem_ack && StallF) begin
                    w_state_nxt = c_ST_HELD;
                end else begin
                    w_state_nxt = c_ST_REQ;
                end
            end
            c_ST_HELD: begin
                if (PCSrcE1bit || !StallF) begin
                    w_state_nxt = c_ST_REQ;
                end
            end
            c_ST_DROP: begin
                // A further redirect while dropping only changes PCF; the
                // killed request is still outstanding until its ack.
                if (imem_ack) begin
                    w_state_nxt = c_ST_REQ;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, request and program counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_req   <= 1'b0;
            r_pcf   <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            // Request is a registered decode of the next state, so imem_addr
            // (PCF) and imem_req change on the same edge.
            r_req   <= (w_state_nxt == c_ST_REQ);
            if (w_pc_load) begin
                r_pcf <= w_pcn_eff;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Holding buffer: captures an acked word while decode is stalled
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_instr <= {DATA_WIDTH{1'b0}};
            r_buf_pc    <= {DATA_WIDTH{1'b0}};
        end else if (PCSrcE1bit) begin
            r_buf_valid <= 1'b0;
        end else if (w_fetch_hold) begin
            r_buf_valid <= 1'b1;
            r_buf_instr <= imem_rdata;
            r_buf_pc    <= r_pcf;
        end else if (w_release) begin
            r_buf_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_d <= c_NOP;
            r_pc_d    <= {DATA_WIDTH{1'b0}};
            r_pcp4_d  <= {DATA_WIDTH{1'b0}};
            r_valid_d <= 1'b0;
        end else if (PCSrcE1bit || FlushD) begin
            // Squash: PCD/PCPlus4D are meaningless with ValidD=0 and are held.
            r_instr_d <= c_NOP;
            r_valid_d <= 1'b0;
        end else if (w_fetch_accept) begin
            r_instr_d <= imem_rdata;
            r_pc_d    <= r_pcf;
            r_pcp4_d  <= r_pcf + c_PC_STEP;
            r_valid_d <= 1'b1;
        end else if (w_release) begin
            r_instr_d <= r_buf_instr;
            r_pc_d    <= r_buf_pc;
            r_pcp4_d  <= r_buf_pc + c_PC_STEP;
            r_valid_d <= 1'b1;
        end else if (!StallF) begin
            // Decode consumed its instruction and nothing new arrived.
            r_valid_d <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Misalignment pulse
    // ------------------------------------------------------------------------
`ifdef PC_MISALIGN_CHECK_EN
    logic r_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_pc_load && (PCN[1:0] != 2'b00);
        end
    end

    assign misaligned_o = r_misaligned;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_req  = r_req;
    assign imem_addr = r_pcf;
    assign PCF       = r_pcf;
    assign PCPlus4F  = r_pcf + c_PC_STEP;
    assign InstrD    = r_instr_d;
    assign PCD       = r_pc_d;
    assign PCPlus4D  = r_pcp4_d;
    assign ValidD    = r_valid_d;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_unit
// Purpose  : Self-checking bench for fetch_pc_unit. A directed vector table
//            on zero-wait memory, directed redirect/misalignment sequences,
//            and a randomized run against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    localparam logic [31:0] c_K   = 32'hA5A5_0000;
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] PCN;
    logic        PCSrcE1bit;
    logic        StallF;
    logic        FlushD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef PC_MISALIGN_CHECK_EN
    logic        misaligned_o;
`endif

    fetch_pc_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCN        (PCN),
        .PCSrcE1bit (PCSrcE1bit),
        .StallF     (StallF),
        .FlushD     (FlushD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
`ifdef PC_MISALIGN_CHECK_EN
        ,
        .misaligned_o (misaligned_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Instruction memory: a request that is not answered at once becomes a
    // pending transaction that is acked mem_lat cycles after it started,
    // whether or not the requester is still asserting imem_req.
    // ------------------------------------------------------------------------
    logic        mem_busy;
    int          mem_cnt;
    int          mem_lat;
    int          lat_mode;    // <0: random 0..2, else fixed latency
    logic [31:0] mem_addr;

    assign imem_ack   = mem_busy ? (mem_cnt == 0) : (imem_req && mem_lat == 0);
    assign imem_rdata = (mem_busy ? mem_addr : imem_addr) ^ c_K;

    // ------------------------------------------------------------------------
    // Reference model (transaction level)
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } word_t;

    logic        m_idle;      // first cycle after reset
    logic        m_kill;      // a killed fetch still owes an ack
    word_t       m_held[$];   // fetched words waiting for decode
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pcp4;
    logic        m_valid;
    logic        m_mis;

    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic load_pc(input logic [31:0] x);
`ifdef PC_MISALIGN_CHECK_EN
        m_pc  = {x[31:2], 2'b00};
        m_mis = (x[1:0] != 2'b00);
`else
        m_pc  = x;
`endif
    endtask

    // Called at a falling edge with inputs already applied. Checks the DUT
    // against the model, advances the model and the memory by one cycle,
    // and returns at the next falling edge.
    task automatic cycle();
        logic  exp_req;
        logic  ack;
        logic  got;
        logic  s_req;
        logic [31:0] s_addr;
        word_t w;
        #1;
        exp_req = !m_idle && (m_held.size() == 0) && !m_kill;
        chk("pcf",       PCF,       m_pc);
        chk("pcplus4f",  PCPlus4F,  m_pc + 32'd4);
        chk("imem_req",  {31'b0, imem_req}, {31'b0, exp_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("validd",    {31'b0, ValidD},   {31'b0, m_valid});
        chk("instrd",    InstrD,    m_instr);
        chk("pcd",       PCD,       m_pcd);
        chk("pcplus4d",  PCPlus4D,  m_pcp4);
`ifdef PC_MISALIGN_CHECK_EN
        chk("misaligned", {31'b0, misaligned_o}, {31'b0, m_mis});
`endif
        ack    = mem_busy ? (mem_cnt == 0) : (exp_req && mem_lat == 0);
        s_req  = imem_req;
        s_addr = imem_addr;

        m_mis = 1'b0;
        got   = 1'b0;
        w.instr = 32'h0;
        w.pc    = 32'h0;
        if (PCSrcE1bit) begin
            if (exp_req && !ack) m_kill = 1'b1;
            else if (m_kill && ack) m_kill = 1'b0;
            m_held.delete();
            load_pc(PCN);
            m_instr = c_NOP;
            m_valid = 1'b0;
        end else begin
            if (m_kill && ack) begin
                m_kill = 1'b0;
            end else if (exp_req && ack) begin
                w.instr = m_pc ^ c_K;
                w.pc    = m_pc;
                if (StallF) m_held.push_back(w);
                else begin got = 1'b1; load_pc(PCN); end
            end else if (m_held.size() > 0 && !StallF) begin
                w   = m_held.pop_front();
                got = 1'b1;
                load_pc(PCN);
            end
            if (FlushD) begin
                m_instr = c_NOP;
                m_valid = 1'b0;
            end else if (got) begin
                m_instr = w.instr;
                m_pcd   = w.pc;
                m_pcp4  = w.pc + 32'd4;
                m_valid = 1'b1;
            end else if (!StallF) begin
                m_valid = 1'b0;
            end
        end
        m_idle = 1'b0;

        @(posedge clk);
        #1;
        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 1'b0;
            else mem_cnt--;
        end else if (s_req && mem_lat != 0) begin
            mem_busy = 1'b1;
            mem_addr = s_addr;
            mem_cnt  = mem_lat - 1;
        end
        if (!mem_busy) mem_lat = (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
        @(negedge clk);
    endtask

    task automatic do_reset(input int lat);
        rst        = 1'b1;
        PCSrcE1bit = 1'b0;
        StallF     = 1'b0;
        FlushD     = 1'b0;
        PCN        = 32'h0;
        lat_mode   = lat;
        @(posedge clk);
        @(posedge clk);
        #1;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        mem_addr = 32'h0;
        mem_lat  = (lat < 0) ? int'($urandom_range(0, 2)) : lat;
        m_idle   = 1'b1;
        m_kill   = 1'b0;
        m_held.delete();
        m_pc     = 32'h0;
        m_instr  = c_NOP;
        m_pcd    = 32'h0;
        m_pcp4   = 32'h0;
        m_valid  = 1'b0;
        m_mis    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table (zero-wait memory). Expected values are what the
    // outputs show during the cycle the inputs are applied.
    // ------------------------------------------------------------------------
    typedef struct {
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] pcn;
        logic [31:0] e_pcf;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_pcd;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic f, input logic r,
                                input logic [31:0] pcn, input logic [31:0] pcf,
                                input logic q, input logic v,
                                input logic [31:0] pcd, input logic [31:0] ins);
        vec_t t;
        t.stall = s; t.flush = f; t.redir = r; t.pcn = pcn;
        t.e_pcf = pcf; t.e_req = q; t.e_valid = v; t.e_pcd = pcd; t.e_instr = ins;
        return t;
    endfunction

    vec_t tbl[17];
    logic bad8;
    logic [31:0] exp_mis_pc;
    logic [31:0] tgt;
    logic redir;

    initial begin
        n_pass  = 0;
        n_total = 0;
        //            st fl rd  PCN            PCF            req val PCD            InstrD
        tbl[0]  = mk(0, 0, 0, 32'h0000_0004, 32'h0000_0000, 0, 0, 32'h0000_0000, c_NOP);
        tbl[1]  = mk(0, 0, 0, 32'h0000_0004, 32'h0000_0000, 1, 0, 32'h0000_0000, c_NOP);
        tbl[2]  = mk(0, 0, 0, 32'h0000_0008, 32'h0000_0004, 1, 1, 32'h0000_0000, 32'hA5A5_0000);
        tbl[3]  = mk(0, 0, 0, 32'h0000_000C, 32'h0000_0008, 1, 1, 32'h0000_0004, 32'hA5A5_0004);
        tbl[4]  = mk(0, 1, 0, 32'h0000_0010, 32'h0000_000C, 1, 1, 32'h0000_0008, 32'hA5A5_0008);
        tbl[5]  = mk(1, 0, 0, 32'h0000_0014, 32'h0000_0010, 1, 0, 32'h0000_0008, c_NOP);
        tbl[6]  = mk(1, 0, 0, 32'h0000_0014, 32'h0000_0010, 0, 0, 32'h0000_0008, c_NOP);
        tbl[7]  = mk(1, 0, 0, 32'h0000_0014, 32'h0000_0010, 0, 0, 32'h0000_0008, c_NOP);
        tbl[8]  = mk(0, 0, 0, 32'h0000_0014, 32'h0000_0010, 0, 0, 32'h0000_0008, c_NOP);
        tbl[9]  = mk(0, 0, 0, 32'h0000_0018, 32'h0000_0014, 1, 1, 32'h0000_0010, 32'hA5A5_0010);
        tbl[10] = mk(0, 0, 1, 32'h0000_0100, 32'h0000_0018, 1, 1, 32'h0000_0014, 32'hA5A5_0014);
        tbl[11] = mk(0, 0, 0, 32'h0000_0104, 32'h0000_0100, 1, 0, 32'h0000_0014, c_NOP);
        tbl[12] = mk(0, 0, 0, 32'h0000_0108, 32'h0000_0104, 1, 1, 32'h0000_0100, 32'hA5A5_0100);
        tbl[13] = mk(0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0108, 1, 1, 32'h0000_0104, 32'hA5A5_0104);
        tbl[14] = mk(0, 0, 0, 32'h0000_0000, 32'hFFFF_FFFC, 1, 0, 32'h0000_0104, c_NOP);
        tbl[15] = mk(0, 0, 0, 32'h0000_0004, 32'h0000_0000, 1, 1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
        tbl[16] = mk(0, 0, 0, 32'h0000_0008, 32'h0000_0004, 1, 1, 32'h0000_0000, 32'hA5A5_0000);

        // ---------------- table-driven, zero-wait memory ----------------
        do_reset(0);
        for (int i = 0; i < 17; i++) begin
            StallF     = tbl[i].stall;
            FlushD     = tbl[i].flush;
            PCSrcE1bit = tbl[i].redir;
            PCN        = tbl[i].pcn;
            #1;
            chk($sformatf("tbl%0d_pcf", i),      PCF,      tbl[i].e_pcf);
            chk($sformatf("tbl%0d_pcplus4f", i), PCPlus4F, tbl[i].e_pcf + 32'd4);
            chk($sformatf("tbl%0d_req", i),      {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            chk($sformatf("tbl%0d_validd", i),   {31'b0, ValidD},   {31'b0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_pcd", i),      PCD,      tbl[i].e_pcd);
            chk($sformatf("tbl%0d_instrd", i),   InstrD,   tbl[i].e_instr);
            cycle();
        end

        // ------- 2-cycle memory, redirect while the fetch at 0x8 is pending -------
        do_reset(2);
        bad8 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            StallF     = 1'b0;
            FlushD     = 1'b0;
            PCSrcE1bit = (k == 9);
            PCN        = (k == 9) ? 32'h0000_0100 : m_pc + 32'd4;
            #1;
            if (k == 8) begin
                chk("drop_req_at_8",  {31'b0, imem_req}, 32'd1);
                chk("drop_addr_at_8", imem_addr, 32'h0000_0008);
            end
            if (k == 10) chk("drop_req_low", {31'b0, imem_req}, 32'd0);
            if (k == 11) begin
                chk("drop_req_target",  {31'b0, imem_req}, 32'd1);
                chk("drop_addr_target", imem_addr, 32'h0000_0100);
            end
            if (ValidD === 1'b1 && PCD === 32'h0000_0008) bad8 = 1'b1;
            cycle();
        end
        chk("drop_no_valid_0x8", {31'b0, bad8}, 32'd0);

        // ---------------- redirect to a misaligned target ----------------
`ifdef PC_MISALIGN_CHECK_EN
        exp_mis_pc = 32'h0000_0100;
`else
        exp_mis_pc = 32'h0000_0102;
`endif
        do_reset(0);
        for (int k = 1; k <= 8; k++) begin
            StallF     = 1'b0;
            FlushD     = 1'b0;
            PCSrcE1bit = (k == 4);
            PCN        = (k == 4) ? 32'h0000_0102 : m_pc + 32'd4;
            #1;
            if (k == 5) chk("misalign_pcf", PCF, exp_mis_pc);
`ifdef PC_MISALIGN_CHECK_EN
            if (k == 5) chk("misalign_pulse", {31'b0, misaligned_o}, 32'd1);
            if (k == 6) chk("misalign_pulse_end", {31'b0, misaligned_o}, 32'd0);
`endif
            cycle();
        end

        // ---------------- randomized run ----------------
        do_reset(-1);
        for (int i = 0; i < 800; i++) begin
            StallF = ($urandom_range(0, 99) < 30);
            FlushD = ($urandom_range(0, 99) < 10);
            redir  = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF8;
            else tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            PCSrcE1bit = redir;
            PCN        = redir ? tgt : m_pc + 32'd4;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
